mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Registers the execute-to-memory bus and captures synchronous data-SRAM read data. The SRAM address and enable are issued in the execute cycle, so read data arrives in the memory cycle.
- Aligns and extends load data, selects the ALU or load result for writeback, and drives a forwarding bus back to decode.
- Holds captured read data across multi-cycle stalls so writeback never sees stale SRAM output.

Parameters:
- EX_TO_MEM_WD, 79, width of incoming execute-to-memory bus.
- MEM_TO_WB_WD, 70, width of outgoing memory-to-writeback bus.
- STALL_W, 6, width of stall vector (matches StallBus).

Ports:
- clk  in  1  pipeline clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  STALL_W  per-stage stop vector; bit 3 = this stage, bit 4 = writeback; 1 = Stop.
- ex_to_mem_bus  in  EX_TO_MEM_WD  {mem_op[2:0] 78:76, pc 75:44, data_ram_en 43, data_ram_wen 42:39, sel_rf_res 38, rf_we 37, rf_waddr 36:32, ex_result 31:0}.
- data_sram_rdata  in  32  SRAM read data, valid in the first cycle an instruction occupies this stage.
- mem_to_wb_bus  out  MEM_TO_WB_WD  {pc 69:38, rf_we 37, rf_waddr 36:32, rf_wdata 31:0}.
- mem_to_id  out  38  {rf_we 37, rf_waddr 36:32, rf_wdata 31:0}, forwarding to decode.
- mem_is_load  out  1  registered instruction is a load (data_ram_en & ~|data_ram_wen).

Behaviour:
- Pipeline register bus_r, EX_TO_MEM_WD bits. Updated in this priority order:
  - rst low (async): bus_r <= 0.
  - stall[3]=Stop & stall[4]=NoStop: bus_r <= 0 (bubble).
  - stall[3]=NoStop: bus_r <= ex_to_mem_bus.
  - Otherwise hold.
- Read-data capture uses two registers, rdata_hold[31:0] and hold_vld:
  - hold_vld clears when bus_r loads new contents (bubble or new instruction) and on reset.
  - When hold_vld=0 and the stage is stalled (stall[3]=Stop), the next edge sets rdata_hold <= data_sram_rdata and hold_vld <= 1.
  - raw_rdata = hold_vld ? rdata_hold : data_sram_rdata.
  - A 1-cycle occupancy uses SRAM data directly. Any longer occupancy uses the value captured on the first cycle.
- Load alignment uses off = ex_result[1:0] and the mem_op encoding below:
  - 000 LW: raw_rdata.
  - 001 LB: sign-extend byte at off (byte0 = bits 7:0, little-endian).
  - 010 LBU: zero-extend byte at off.
  - 011 LH: sign-extend half selected by off[1]; off[0] ignored.
  - 100 LHU: zero-extend half selected by off[1].
  - 101-111: treated as LW.
- Writeback data: rf_wdata = sel_rf_res ? load_data : ex_result.
- Stores (wen != 0) and bubbles pass ex_result unchanged. A bubble carries rf_we=0.
- mem_to_wb_bus and mem_to_id are combinational from bus_r and the raw_rdata path, with no added latency.
- Reset values: all outputs 0, hold_vld=0, rdata_hold=0.
- Reset mid-stall: hold is discarded and the next instruction captures fresh data.
- Simultaneous bubble insert and capture: the bubble wins, hold_vld=0.

Test Plan:
- LW at addr 0x100, rdata=0x8899AABB, no stall -> next cycle rf_wdata=0x8899AABB, rf_we=1, mem_is_load=1.
- LB addr 0x103, rdata=0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011; LHU -> 0x00008011.
- LW with stall[3]=stall[4]=Stop for 3 cycles, SRAM rdata changes to 0xDEADBEEF after cycle 1 -> rf_wdata stays at the first-cycle value 0x12345678 throughout.
- stall[3]=Stop, stall[4]=NoStop -> next cycle mem_to_wb_bus = 0, rf_we=0.
- SW, ex_result=0x200, sel_rf_res=0 -> rf_wdata=0x200, rf_we=0, mem_is_load=0.
- Assert rst low mid-stall with hold_vld=1 -> outputs 0 immediately, hold_vld=0; after release the next LW uses live SRAM data.

Source files
------------

// File: rtl/mem_stage_if.sv
// Execute/memory/writeback-facing signal bundle for the MIPS memory-access stage.
// The slave side is the stage itself; the master side is the surrounding pipeline.
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_W      = 6
);
  logic [STALL_W-1:0]      stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [37:0]             mem_to_id;
  logic                    mem_is_load;

  modport master (
    output stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id, mem_is_load
  );

  modport slave (
    input  stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id, mem_is_load
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: registers the execute bus, captures SRAM read data
// across stalls, aligns/extends loads and drives writeback and forwarding buses.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  mem_stage_if.slave   bus
);
  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [EX_TO_MEM_WD-1:0] bus_reg;
  logic [31:0]             rdata_hold_reg;
  logic                    hold_vld_reg;

  logic        stop_mem;
  logic        stop_wb;
  logic [2:0]  mem_op;
  logic [31:0] pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  off;
  logic [31:0] raw_rdata;
  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  assign stop_mem = bus.stall[3];
  assign stop_wb  = bus.stall[4];

  assign {mem_op, pc, data_ram_en, data_ram_wen, sel_rf_res,
          rf_we, rf_waddr, ex_result} = bus_reg;
  assign off = ex_result[1:0];

  // A bubble or a new instruction invalidates the held read data; otherwise the
  // first stalled cycle latches the SRAM output so later cycles see that value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_reg        <= '0;
      rdata_hold_reg <= '0;
      hold_vld_reg   <= 1'b0;
    end else if (stop_mem && !stop_wb) begin
      bus_reg      <= '0;
      hold_vld_reg <= 1'b0;
    end else if (!stop_mem) begin
      bus_reg      <= bus.ex_to_mem_bus;
      hold_vld_reg <= 1'b0;
    end else if (!hold_vld_reg) begin
      rdata_hold_reg <= bus.data_sram_rdata;
      hold_vld_reg   <= 1'b1;
    end
  end

  assign raw_rdata = hold_vld_reg ? rdata_hold_reg : bus.data_sram_rdata;

  // Little-endian byte lanes: lane 0 is bits 7:0.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = raw_rdata[8*gi +: 8];
  end

  assign sel_byte = byte_lane[off];
  assign sel_half = off[1] ? raw_rdata[31:16] : raw_rdata[15:0];

  always_comb begin
    load_data = raw_rdata;
    case (mem_op)
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'd0, sel_byte};
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'd0, sel_half};
      OP_LW:   load_data = raw_rdata;
      default: load_data = raw_rdata;
    endcase
  end

  assign rf_wdata = sel_rf_res ? load_data : ex_result;

  assign bus.mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign bus.mem_to_id     = {rf_we, rf_waddr, rf_wdata};
  assign bus.mem_is_load   = data_ram_en & ~|data_ram_wen;
endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage with hand-written stall/bubble/reset sequences.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_stage_if #(.EX_TO_MEM_WD(79), .MEM_TO_WB_WD(70), .STALL_W(6)) io ();

  mem_stage #(.EX_TO_MEM_WD(79), .MEM_TO_WB_WD(70), .STALL_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] pc;
    logic        en;
    logic [3:0]  wen;
    logic        sel;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_load;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [78:0] mk_ex(input logic [2:0] op, input logic [31:0] pc,
                                        input logic en, input logic [3:0] wen,
                                        input logic sel, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] res);
    return {op, pc, en, wen, sel, we, waddr, res};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic [31:0] pc, input logic we,
                           input logic [4:0] waddr, input logic [31:0] wdata,
                           input logic is_load);
    check({name, ".wb"}, io.mem_to_wb_bus, {pc, we, waddr, wdata});
    check({name, ".id"}, {32'd0, io.mem_to_id}, {32'd0, we, waddr, wdata});
    check({name, ".ld"}, {69'd0, io.mem_is_load}, {69'd0, is_load});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    //          op    pc          en wen    sel we waddr res           rdata         exp_wdata     load
    vecs[0]  = '{3'd0, 32'h1000, 1, 4'h0, 1, 1, 5'd2, 32'h0000_0100, 32'h8899_AABB, 32'h8899_AABB, 1};
    vecs[1]  = '{3'd1, 32'h1004, 1, 4'h0, 1, 1, 5'd3, 32'h0000_0103, 32'h8011_2233, 32'hFFFF_FF80, 1};
    vecs[2]  = '{3'd2, 32'h1008, 1, 4'h0, 1, 1, 5'd4, 32'h0000_0103, 32'h8011_2233, 32'h0000_0080, 1};
    vecs[3]  = '{3'd3, 32'h100C, 1, 4'h0, 1, 1, 5'd5, 32'h0000_0102, 32'h8011_2233, 32'hFFFF_8011, 1};
    vecs[4]  = '{3'd4, 32'h1010, 1, 4'h0, 1, 1, 5'd6, 32'h0000_0102, 32'h8011_2233, 32'h0000_8011, 1};
    vecs[5]  = '{3'd0, 32'h1014, 1, 4'hF, 0, 0, 5'd0, 32'h0000_0200, 32'h5A5A_5A5A, 32'h0000_0200, 0};
    vecs[6]  = '{3'd1, 32'h1018, 1, 4'h0, 1, 1, 5'd7, 32'h0000_0101, 32'h1234_5678, 32'h0000_0056, 1};
    vecs[7]  = '{3'd3, 32'h101C, 1, 4'h0, 1, 1, 5'd8, 32'h0000_0101, 32'h1234_F678, 32'hFFFF_F678, 1};
    vecs[8]  = '{3'd7, 32'h1020, 1, 4'h0, 1, 1, 5'd9, 32'h0000_0000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1};
    vecs[9]  = '{3'd0, 32'h1024, 0, 4'h0, 0, 1, 5'd10, 32'h0000_0055, 32'hFFFF_FFFF, 32'h0000_0055, 0};
    vecs[10] = '{3'd2, 32'h1028, 1, 4'h0, 1, 1, 5'd11, 32'h0000_0100, 32'h0000_00FF, 32'h0000_00FF, 1};

    io.stall = '0;
    io.ex_to_mem_bus = '0;
    io.data_sram_rdata = 32'hFFFF_FFFF;
    io.ex_to_mem_bus = mk_ex(3'd0, 32'hAAAA, 1, 4'h0, 1, 1, 5'd1, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      io.stall = '0;
      io.ex_to_mem_bus = mk_ex(vecs[i].op, vecs[i].pc, vecs[i].en, vecs[i].wen,
                               vecs[i].sel, vecs[i].we, vecs[i].waddr, vecs[i].res);
      @(posedge clk);
      #1 io.data_sram_rdata = vecs[i].rdata;
      #1;
      $display("vec %0d: op=%0d res=%h rdata=%h wdata=%h", i, vecs[i].op, vecs[i].res,
               vecs[i].rdata, io.mem_to_id[31:0]);
      check_out($sformatf("vec%0d", i), vecs[i].pc, vecs[i].we, vecs[i].waddr,
                vecs[i].exp_wdata, vecs[i].exp_load);
    end

    // Multi-cycle stall: read data must stay at the first-cycle value.
    io.stall = '0;
    io.ex_to_mem_bus = mk_ex(3'd0, 32'h400, 1, 4'h0, 1, 1, 5'd7, 32'h300);
    @(posedge clk);
    #1 io.data_sram_rdata = 32'h1234_5678;
    io.stall = 6'b011000;
    io.ex_to_mem_bus = mk_ex(3'd0, 32'h404, 0, 4'h0, 0, 1, 5'd3, 32'h999);
    #1 check("stall_c0", io.mem_to_wb_bus, {32'h400, 1'b1, 5'd7, 32'h1234_5678});
    $display("stall cycle 0: wdata=%h", io.mem_to_id[31:0]);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1 io.data_sram_rdata = 32'hDEAD_BEEF;
      #1 check($sformatf("stall_c%0d", c), io.mem_to_wb_bus, {32'h400, 1'b1, 5'd7, 32'h1234_5678});
      $display("stall cycle %0d: wdata=%h", c, io.mem_to_id[31:0]);
    end
    io.stall = '0;
    @(posedge clk);
    #2 check("after_stall", io.mem_to_wb_bus, {32'h404, 1'b1, 5'd3, 32'h999});
    $display("after stall: wdata=%h", io.mem_to_id[31:0]);

    // Bubble insertion: stage stopped, writeback running.
    io.ex_to_mem_bus = mk_ex(3'd0, 32'h500, 1, 4'h0, 1, 1, 5'd12, 32'h10);
    @(posedge clk);
    #1 io.data_sram_rdata = 32'h1111_1111;
    #1 check("pre_bubble", io.mem_to_wb_bus, {32'h500, 1'b1, 5'd12, 32'h1111_1111});
    io.stall = 6'b001000;
    @(posedge clk);
    #2;
    $display("bubble: wb=%h", io.mem_to_wb_bus);
    check_out("bubble", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    io.stall = '0;

    // Reset in the middle of a stall with held data.
    io.ex_to_mem_bus = mk_ex(3'd0, 32'h600, 1, 4'h0, 1, 1, 5'd9, 32'h104);
    @(posedge clk);
    #1 io.data_sram_rdata = 32'hAAAA_5555;
    io.stall = 6'b011000;
    #1 check("rst_pre0", io.mem_to_wb_bus, {32'h600, 1'b1, 5'd9, 32'hAAAA_5555});
    @(posedge clk);
    #1 io.data_sram_rdata = 32'hBBBB_0000;
    #1 check("rst_pre1", io.mem_to_wb_bus, {32'h600, 1'b1, 5'd9, 32'hAAAA_5555});
    rst = 1'b0;
    #1;
    $display("reset mid-stall: wb=%h", io.mem_to_wb_bus);
    check_out("rst_mid", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    io.stall = '0;
    io.ex_to_mem_bus = mk_ex(3'd0, 32'h700, 1, 4'h0, 1, 1, 5'd10, 32'h108);
    @(posedge clk);
    #1 io.data_sram_rdata = 32'hC0FF_EE00;
    #1 check("rst_after", io.mem_to_wb_bus, {32'h700, 1'b1, 5'd10, 32'hC0FF_EE00});
    $display("after reset: wdata=%h", io.mem_to_id[31:0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
